// File: rtl/dac_frame_feeder.sv
// rtl/dac_frame_feeder.sv - paces buffered 12-bit sample pairs to the dual-channel SPI DAC serializer
module dac_frame_feeder #(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 16,
    parameter int RATE_DIV = 2500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_ch1,
    input  logic [DATA_W-1:0]        in_ch2,
    input  logic                     dac_ready,
    output logic                     load,
    output logic [DATA_W-1:0]        ch1_out,
    output logic [DATA_W-1:0]        ch2_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              underrun_cnt,
    output logic                     late
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(RATE_DIV);
    localparam logic [DATA_W-1:0] MID_SCALE = DATA_W'(1) << (DATA_W - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic               tick;

    logic [DATA_W-1:0]  mem_ch1 [DEPTH];
    logic [DATA_W-1:0]  mem_ch2 [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               pop;

    assign empty    = (count == '0);
    assign in_ready = !full;
    assign wr_en    = in_valid && !full;
    // The head is only consumed when a frame is actually handed over.
    assign pop      = (state == WAIT) && dac_ready && !empty;
    assign level    = count;
    assign load     = (state == ISSUE);
    assign tick     = en && (timer == TMR_W'(RATE_DIV - 1));

    // Sample-period timer; held at zero while pacing is disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Sample storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_ch1[wr_ptr] <= in_ch1;
            mem_ch2[wr_ptr] <= in_ch2;
        end
    end

    // FIFO pointers, occupancy and registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10: begin
                    count <= count + (PTR_W+1)'(1);
                    full  <= (count == (PTR_W+1)'(DEPTH - 1));
                end
                2'b01: begin
                    count <= count - (PTR_W+1)'(1);
                    full  <= 1'b0;
                end
                default: begin
                    count <= count;
                    full  <= full;
                end
            endcase
        end
    end

    // Frame handshake FSM: registers the outgoing pair, tracks underruns and dropped ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ch1_out      <= MID_SCALE;
            ch2_out      <= MID_SCALE;
            underrun_cnt <= '0;
            late         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A tick arriving while the previous frame is still pending is lost.
                    if (tick) begin
                        late <= 1'b1;
                    end
                    if (dac_ready) begin
                        state <= ISSUE;
                        if (!empty) begin
                            ch1_out <= mem_ch1[rd_ptr];
                            ch2_out <= mem_ch2[rd_ptr];
                        end else if (underrun_cnt != 16'hFFFF) begin
                            underrun_cnt <= underrun_cnt + 16'd1;
                        end
                    end
                end
                ISSUE: begin
                    state <= tick ? WAIT : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/dac_frame_feeder.md
# dac_frame_feeder

Sample-pacing stage directly upstream of the dual-channel SPI DAC serializer. Buffers 12-bit sample pairs (channel 1 / channel 2) from a waveform source in a small FIFO and hands exactly one pair to the serializer per sample period, using a load/ready handshake. Underruns repeat the last pair. Overruns, where the serializer is still busy at the next period, are flagged.

## Interface
- DATA_W, 12, sample width per channel (DAC code, straight binary)
- DEPTH, 16, FIFO depth in sample pairs; must be a power of two, ≥2
- RATE_DIV, 2500, clk cycles per sample period (2500 = 40 kS/s at 100 MHz); ≥4
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  enable sample pacing (switch-driven)
- in_valid  in  1  source presents a sample pair
- in_ready  out  1  FIFO can accept; equals !full
- in_ch1  in  DATA_W  channel-1 sample
- in_ch2  in  DATA_W  channel-2 sample
- dac_ready  in  1  serializer idle and able to take a frame
- load  out  1  one-cycle pulse: ch1_out/ch2_out hold a new frame
- ch1_out  out  DATA_W  channel-1 code to serializer
- ch2_out  out  DATA_W  channel-2 code to serializer
- level  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- underrun_cnt  out  16  frames issued from an empty FIFO, saturating at 16'hFFFF
- late  out  1  sticky: a period tick was dropped because the previous frame was not yet issued

## Operation
- FIFO
  - A write occurs when in_valid && in_ready.
  - A pop occurs only on the WAIT→ISSUE transition when the FIFO is non-empty.
  - There is no fall-through: a write into an empty FIFO is poppable from the next cycle onward.
  - A simultaneous write and pop on a non-empty, non-full FIFO both succeed, and level is unchanged.
  - At full, in_ready=0 and in_valid is ignored. Pointers wrap modulo DEPTH.
- Rate timer
  - Counter runs 0..RATE_DIV-1 while en=1.
  - tick is asserted internally on the cycle the counter equals RATE_DIV-1; the counter then wraps to 0.
  - en=0: counter is forced to 0 and no ticks occur.
- FSM states: IDLE, WAIT, ISSUE.
  - IDLE → WAIT on tick.
  - WAIT → ISSUE when dac_ready=1. On this edge, ch1_out/ch2_out are registered:
    - FIFO non-empty: take the FIFO head and pop.
    - FIFO empty: keep the previous values and increment underrun_cnt (saturating).
  - WAIT stays in WAIT while dac_ready=0. A tick in WAIT is dropped and sets late=1.
  - ISSUE → WAIT if a tick occurs in that cycle; otherwise ISSUE → IDLE.
  - load = (state == ISSUE).
- en deasserted mid-frame: a pending WAIT/ISSUE still completes; no new ticks are generated.
- late and underrun_cnt are cleared only by rst.

## Timing
- Reset values (the cycle after rst is sampled high):
  - state=IDLE, timer=0, FIFO empty, level=0, in_ready=1
  - load=0, ch1_out=ch2_out=12'h800 (mid-scale), underrun_cnt=0, late=0
- rst mid-operation aborts any pending frame and discards FIFO contents. No load is issued until a fresh tick occurs.
- Latency from tick at cycle T with dac_ready=1 at T+1:
  - load=1 at T+2, with the new ch1_out/ch2_out already valid in that cycle.
  - ch1_out/ch2_out then hold until the next load.
- First tick after en rises: RATE_DIV cycles after en is first sampled high.
- level updates the cycle after each write/pop. in_ready is combinational from the registered full flag.
- At most one load per RATE_DIV cycles. load is never asserted on two consecutive cycles.

## Test plan
- Reset/idle
  - Stimulus: hold rst 3 cycles, en=0, dac_ready=1.
  - Required: load never pulses; ch outputs read 0x800; level=0; in_ready=1.
- Steady stream (RATE_DIV=10, DEPTH=4)
  - Stimulus: write pairs (0x001,0xFFF), (0x002,0xFFE), (0x003,0xFFD); en=1; dac_ready=1.
  - Required: loads spaced exactly 10 cycles apart, carrying those pairs in order; level goes 3→0; underrun_cnt=0.
- Underrun
  - Stimulus: continue the steady-stream case with no further writes for 2 periods.
  - Required: two more loads, both repeating (0x003,0xFFD); underrun_cnt=2.
- Full FIFO
  - Stimulus: en=0; hold in_valid=1 with 5 distinct pairs.
  - Required: 4 accepted; in_ready=0 at level=4; the 5th pair is not written.
  - Follow-up: en=1. Required: the first 4 pairs emerge in order.
- Busy serializer
  - Stimulus: dac_ready=0 for 25 cycles spanning two ticks.
  - Required: late=1; exactly one load after dac_ready rises; that load pops exactly one pair.
- Reset mid-frame
  - Stimulus: assert rst in the WAIT state with level=2.
  - Required: no load; level=0; ch outputs 0x800; late and underrun_cnt cleared.
